// File: rtl/pasc_output_fifo.sv
// pasc_output_fifo
// Collects pasc per-core output events into a FIFO and streams them out as
// an AXI4-Stream master. The stream word sits in a registered output stage
// that counts as one of the DEPTH slots. Events that arrive while the FIFO
// is full and nothing drains are dropped. Drops are recorded in a sticky
// flag and in a saturating counter, so software can tell results were lost.
module pasc_output_fifo #(
  parameter int NUM_CORES     = 16,
  parameter int CORE_ID_WIDTH = $clog2(NUM_CORES),
  parameter int DEPTH         = 16,
  parameter int COUNT_WIDTH   = $clog2(DEPTH + 1)
) (
  input  logic                     s_axi_aclk,
  input  logic                     s_axi_aresetn,
  input  logic                     output_enable,
  input  logic [CORE_ID_WIDTH-1:0] output_core_id,
  input  logic [15:0]              output_data_val,
  input  logic                     clear,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [31:0]              m_axis_tdata,
  output logic [COUNT_WIDTH-1:0]   fifo_count,
  output logic                     fifo_full,
  output logic                     overflow,
  output logic [15:0]              overflow_count
);

  localparam int PTR_WIDTH   = $clog2(DEPTH);
  localparam int ENTRY_WIDTH = CORE_ID_WIDTH + 16;

  localparam logic [COUNT_WIDTH-1:0] CNT_ZERO = COUNT_WIDTH'(0);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH-1:0] CNT_FULL = COUNT_WIDTH'(DEPTH);
  localparam logic [PTR_WIDTH-1:0]   PTR_ZERO = PTR_WIDTH'(0);
  localparam logic [PTR_WIDTH-1:0]   PTR_ONE  = PTR_WIDTH'(1);

  // Fill level of the whole FIFO (memory plus output stage), taken from the count
  typedef enum logic [1:0] {
    FILL_EMPTY   = 2'd0,
    FILL_PARTIAL = 2'd1,
    FILL_FULL    = 2'd2
  } fill_state_e;

  // Storage and registered state
  logic [ENTRY_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr_r;
  logic [PTR_WIDTH-1:0]   rd_ptr_r;
  logic [COUNT_WIDTH-1:0] count_r;
  logic                   full_r;
  logic                   tvalid_r;
  logic [31:0]            tdata_r;
  logic                   overflow_r;
  logic [15:0]            ovf_cnt_r;

  // Combinational control
  fill_state_e            fill_state_s;
  logic                   pop_s;
  logic                   push_s;
  logic                   drop_s;
  logic [COUNT_WIDTH-1:0] mem_used_s;
  logic                   mem_avail_s;
  logic                   load_s;
  logic [COUNT_WIDTH-1:0] count_nxt_s;
  logic                   full_nxt_s;
  logic [15:0]            ovf_cnt_nxt_s;

  // Derive the fill state from the registered count only
  always_comb begin
    fill_state_s = FILL_EMPTY;
    if (count_r == CNT_ZERO) begin
      fill_state_s = FILL_EMPTY;
    end else if (count_r == CNT_FULL) begin
      fill_state_s = FILL_FULL;
    end else begin
      fill_state_s = FILL_PARTIAL;
    end
  end

  // Decide push, pop and drop. A push is accepted while full only when the
  // output word leaves in the same cycle.
  always_comb begin
    pop_s  = tvalid_r && m_axis_tready;
    push_s = 1'b0;
    drop_s = 1'b0;
    case (fill_state_s)
      FILL_FULL: begin
        if (output_enable) begin
          if (pop_s) begin
            push_s = 1'b1;
            drop_s = 1'b0;
          end else begin
            push_s = 1'b0;
            drop_s = 1'b1;
          end
        end else begin
          push_s = 1'b0;
          drop_s = 1'b0;
        end
      end
      default: begin
        push_s = output_enable;
        drop_s = 1'b0;
      end
    endcase
  end

  // Refill the output stage from memory when it is empty or being consumed.
  // Memory occupancy is the total count minus the word already presented.
  always_comb begin
    mem_used_s  = count_r - {{(COUNT_WIDTH-1){1'b0}}, tvalid_r};
    mem_avail_s = (mem_used_s != CNT_ZERO);
    load_s      = mem_avail_s && (!tvalid_r || pop_s);
  end

  // Next count and full flag: push-only +1, pop-only -1, both or neither hold
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
    full_nxt_s = (count_nxt_s == CNT_FULL);
  end

  // Saturating drop counter: stops at all-ones and never wraps
  always_comb begin
    ovf_cnt_nxt_s = ovf_cnt_r;
    if (drop_s && (ovf_cnt_r != 16'hFFFF)) begin
      ovf_cnt_nxt_s = ovf_cnt_r + 16'd1;
    end else begin
      ovf_cnt_nxt_s = ovf_cnt_r;
    end
  end

  // Event storage write; a push coinciding with clear is discarded
  always_ff @(posedge s_axi_aclk) begin
    if (push_s && !clear) begin
      mem_r[wr_ptr_r] <= {output_core_id, output_data_val};
    end
  end

  // FIFO control, output stage and overflow tracking; clear has top priority
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      full_r     <= 1'b0;
      tvalid_r   <= 1'b0;
      tdata_r    <= 32'h0000_0000;
      overflow_r <= 1'b0;
      ovf_cnt_r  <= 16'h0000;
    end else if (clear) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      count_r    <= CNT_ZERO;
      full_r     <= 1'b0;
      tvalid_r   <= 1'b0;
      tdata_r    <= 32'h0000_0000;
      overflow_r <= 1'b0;
      ovf_cnt_r  <= 16'h0000;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (load_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
        tdata_r  <= 32'(mem_r[rd_ptr_r]);
        tvalid_r <= 1'b1;
      end else if (pop_s) begin
        tvalid_r <= 1'b0;
      end
      count_r   <= count_nxt_s;
      full_r    <= full_nxt_s;
      ovf_cnt_r <= ovf_cnt_nxt_s;
      if (drop_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign m_axis_tvalid  = tvalid_r;
  assign m_axis_tdata   = tdata_r;
  assign fifo_count     = count_r;
  assign fifo_full      = full_r;
  assign overflow       = overflow_r;
  assign overflow_count = ovf_cnt_r;

endmodule

// File: tb/tb_pasc_output_fifo.sv
// Bench for pasc_output_fifo: a queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_pasc_output_fifo;

  localparam int D = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  id = 4'h0;
  logic [15:0] val = 16'h0000;
  logic        clr = 1'b0;
  logic        rdy = 1'b0;
  logic        tvalid;
  logic [31:0] tdata;
  logic [4:0]  cnt;
  logic        full;
  logic        ovf;
  logic [15:0] ovc;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  pasc_output_fifo #(.NUM_CORES(16), .DEPTH(D)) dut (
    .s_axi_aclk     (clk),
    .s_axi_aresetn  (rst_n),
    .output_enable  (en),
    .output_core_id (id),
    .output_data_val(val),
    .clear          (clr),
    .m_axis_tvalid  (tvalid),
    .m_axis_tready  (rdy),
    .m_axis_tdata   (tdata),
    .fifo_count     (cnt),
    .fifo_full      (full),
    .overflow       (ovf),
    .overflow_count (ovc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the queue holds every entry; the head is visible on the
  // stream once it has been stored for at least one full edge.
  typedef struct {
    logic [31:0] word;
    int          stored;
  } ent_t;

  ent_t        mq[$];
  bit          m_valid = 1'b0;
  bit          m_ovf = 1'b0;
  logic [15:0] m_ovc = 16'h0000;
  int          edge_n = 0;

  always @(negedge rst_n) begin
    mq.delete();
    m_valid = 1'b0;
    m_ovf   = 1'b0;
    m_ovc   = 16'h0000;
  end

  always @(posedge clk) begin
    bit pop;
    bit is_full;
    edge_n++;
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_ovc = 16'h0000;
    end else if (clr) begin
      mq.delete();
      m_ovf = 1'b0;
      m_ovc = 16'h0000;
    end else begin
      pop     = m_valid && rdy;
      is_full = (mq.size() == D);
      if (pop) void'(mq.pop_front());
      if (en) begin
        if (!is_full || pop) begin
          mq.push_back('{word: {12'h000, id, val}, stored: edge_n});
        end else begin
          m_ovf = 1'b1;
          if (m_ovc != 16'hFFFF) m_ovc = m_ovc + 16'd1;
        end
      end
    end
    m_valid = (mq.size() > 0) && (mq[0].stored < edge_n);
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      check("tvalid", {31'd0, tvalid}, {31'd0, m_valid});
      check("fifo_count", {27'd0, cnt}, 32'(mq.size()));
      check("fifo_full", {31'd0, full}, {31'd0, (mq.size() == D)});
      check("overflow", {31'd0, ovf}, {31'd0, m_ovf});
      check("overflow_count", {16'd0, ovc}, {16'd0, m_ovc});
      if (m_valid) check("tdata", tdata, mq[0].word);
    end
  end

  // Record every word accepted by the downstream
  logic [31:0] got[$];
  always @(posedge clk) begin
    if (rst_n && tvalid && rdy) got.push_back(tdata);
  end

  task automatic drive(input logic e, input logic [3:0] i, input logic [15:0] v,
                       input logic r, input logic c);
    @(negedge clk);
    en  = e;
    id  = i;
    val = v;
    rdy = r;
    clr = c;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    #12;
    check("rst_tvalid", {31'd0, tvalid}, 32'd0);
    check("rst_tdata", tdata, 32'd0);
    check("rst_count", {27'd0, cnt}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_overflow", {31'd0, ovf}, 32'd0);
    check("rst_ovc", {16'd0, ovc}, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Basic path
    got.delete();
    drive(1'b1, 4'h3, 16'hBEEF, 1'b1, 1'b0);
    drive(1'b0, 4'h0, 16'h0000, 1'b1, 1'b0);
    check("basic_count_after_capture", {27'd0, cnt}, 32'd1);
    check("basic_tvalid_latency", {31'd0, tvalid}, 32'd0);
    drive(1'b0, 4'h0, 16'h0000, 1'b1, 1'b0);
    check("basic_tvalid", {31'd0, tvalid}, 32'd1);
    check("basic_tdata", tdata, 32'h0003BEEF);
    drive(1'b0, 4'h0, 16'h0000, 1'b1, 1'b0);
    check("basic_count_end", {27'd0, cnt}, 32'd0);
    check("basic_words", 32'(got.size()), 32'd1);
    check("basic_word0", got[0], 32'h0003BEEF);

    // Back-to-back: values 1..8
    got.delete();
    for (int i = 1; i <= 8; i++) drive(1'b1, 4'(i), 16'(i), 1'b1, 1'b0);
    repeat (4) drive(1'b0, 4'h0, 16'h0000, 1'b1, 1'b0);
    check("b2b_words", 32'(got.size()), 32'd8);
    for (int k = 0; k < 8; k++)
      check("b2b_word", got[k], {12'h000, 4'(k + 1), 16'(k + 1)});
    check("b2b_overflow", {31'd0, ovf}, 32'd0);

    // Fill and overflow: 20 events, no drain
    got.delete();
    for (int i = 0; i < 20; i++) drive(1'b1, 4'(i), 16'h0100 + 16'(i), 1'b0, 1'b0);
    drive(1'b0, 4'h0, 16'h0000, 1'b0, 1'b0);
    check("fill_count", {27'd0, cnt}, 32'd16);
    check("fill_full", {31'd0, full}, 32'd1);
    check("fill_overflow", {31'd0, ovf}, 32'd1);
    check("fill_ovc", {16'd0, ovc}, 32'd4);
    repeat (20) drive(1'b0, 4'h0, 16'h0000, 1'b1, 1'b0);
    check("drain_words", 32'(got.size()), 32'd16);
    for (int k = 0; k < 16; k++)
      check("drain_word", got[k], {12'h000, 4'(k), 16'h0100 + 16'(k)});
    check("drain_count", {27'd0, cnt}, 32'd0);

    // Full with concurrent push and pop
    got.delete();
    for (int i = 0; i < 16; i++) drive(1'b1, 4'hA, 16'h0200 + 16'(i), 1'b0, 1'b0);
    drive(1'b1, 4'hB, 16'hAAAA, 1'b1, 1'b0);
    drive(1'b0, 4'h0, 16'h0000, 1'b0, 1'b0);
    check("pp_count", {27'd0, cnt}, 32'd16);
    check("pp_ovc", {16'd0, ovc}, 32'd4);
    repeat (20) drive(1'b0, 4'h0, 16'h0000, 1'b1, 1'b0);
    check("pp_words", 32'(got.size()), 32'd17);
    check("pp_first", got[0], 32'h000A0200);
    check("pp_last", got[16], 32'h000BAAAA);

    // Clear versus push: 5 entries held, 3 drops recorded
    drive(1'b0, 4'h0, 16'h0000, 1'b0, 1'b1);
    for (int i = 0; i < 19; i++) drive(1'b1, 4'h5, 16'h0300 + 16'(i), 1'b0, 1'b0);
    repeat (11) drive(1'b0, 4'h0, 16'h0000, 1'b1, 1'b0);
    drive(1'b0, 4'h0, 16'h0000, 1'b0, 1'b0);
    check("pre_clear_count", {27'd0, cnt}, 32'd5);
    check("pre_clear_ovc", {16'd0, ovc}, 32'd3);
    drive(1'b1, 4'h5, 16'hDEAD, 1'b0, 1'b1);
    got.delete();
    drive(1'b0, 4'h0, 16'h0000, 1'b1, 1'b0);
    check("clear_count", {27'd0, cnt}, 32'd0);
    check("clear_tvalid", {31'd0, tvalid}, 32'd0);
    check("clear_ovc", {16'd0, ovc}, 32'd0);
    check("clear_overflow", {31'd0, ovf}, 32'd0);
    repeat (3) drive(1'b0, 4'h0, 16'h0000, 1'b1, 1'b0);
    check("clear_no_words", 32'(got.size()), 32'd0);

    // Asynchronous reset between edges while a word is held
    drive(1'b1, 4'h7, 16'h4242, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 16'h0000, 1'b0, 1'b0);
    drive(1'b0, 4'h0, 16'h0000, 1'b0, 1'b0);
    check("ar_tvalid_before", {31'd0, tvalid}, 32'd1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_tvalid", {31'd0, tvalid}, 32'd0);
    check("ar_count", {27'd0, cnt}, 32'd0);
    check("ar_tdata", tdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy   = 1'b1;
    got.delete();
    repeat (4) drive(1'b0, 4'h0, 16'h0000, 1'b1, 1'b0);
    check("ar_no_stale", 32'(got.size()), 32'd0);
    drive(1'b1, 4'hF, 16'h1234, 1'b1, 1'b0);
    drive(1'b0, 4'h0, 16'h0000, 1'b1, 1'b0);
    drive(1'b0, 4'h0, 16'h0000, 1'b1, 1'b0);
    check("ar_new_tvalid", {31'd0, tvalid}, 32'd1);
    check("ar_new_tdata", tdata, 32'h000F1234);
    drive(1'b0, 4'h0, 16'h0000, 1'b1, 1'b0);
    check("ar_new_words", 32'(got.size()), 32'd1);
    check("ar_new_word", got[0], 32'h000F1234);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pasc_output_fifo.md
Name: pasc_output_fifo

Overview:
- Downstream consumer of the pasc output port (output_enable / output_core_id / output_data_val), which axi_interface currently leaves unconnected.
- Captures each per-core output event into a FIFO and drains it as an AXI4-Stream master toward a DMA or host-side collector.
- Counts dropped events on overflow, so software can detect lost results.

Parameters:
- NUM_CORES, 16, number of pasc cores; sets the core-id width.
- CORE_ID_WIDTH, $clog2(NUM_CORES), width of output_core_id.
- DEPTH, 16, FIFO entries; must be a power of two and >= 2.
- COUNT_WIDTH, $clog2(DEPTH + 1), width of fifo_count.

Ports:
- s_axi_aclk  input  1  clock; the only clock.
- s_axi_aresetn  input  1  asynchronous active-low reset.
- output_enable  input  1  pasc output event strobe; one event per cycle high.
- output_core_id  input  CORE_ID_WIDTH  core that produced the event.
- output_data_val  input  16  event value.
- clear  input  1  synchronous flush of the FIFO and the overflow state.
- m_axis_tvalid  output  1  stream word valid.
- m_axis_tready  input  1  downstream accepts the word.
- m_axis_tdata  output  32  [15:0] value, [16+CORE_ID_WIDTH-1:16] core id, remaining bits zero.
- fifo_count  output  COUNT_WIDTH  entries held, including the word presented on the stream.
- fifo_full  output  1  fifo_count == DEPTH.
- overflow  output  1  sticky flag: at least one event has been dropped.
- overflow_count  output  16  dropped events, saturating at 16'hFFFF.

Behaviour:
- Reset (async assert, sync-to-clock release): the following are 0 immediately, without waiting for a clock edge:
  - m_axis_tvalid, m_axis_tdata, fifo_count, fifo_full, overflow, overflow_count;
  - read/write pointers.
  - Reset mid-transfer discards all contents; no word is replayed after release.
- Storage:
  - DEPTH x (CORE_ID_WIDTH + 16) array; write and read pointers of $clog2(DEPTH) bits that wrap naturally.
  - Full/empty are derived from the registered count.
- Push: output_enable high on rising edge N and the FIFO accepts → the entry is stored at edge N.
  - If the FIFO was empty, m_axis_tvalid = 1 with that data after edge N+1 (registered output stage, latency 1).
  - The output stage counts as one FIFO slot, so total capacity is DEPTH.
- Pop: a word transfers on an edge where m_axis_tvalid && m_axis_tready.
  - The next entry appears on the following cycle with no bubble when the FIFO is not empty.
  - Otherwise m_axis_tvalid falls to 0.
- AXIS rules:
  - m_axis_tvalid never depends combinationally on m_axis_tready.
  - Once tvalid is asserted, tdata is held stable until transfer.
- Simultaneous push and pop:
  - Count is unchanged.
  - When full, the push is accepted because a slot frees in the same cycle, so no overflow is recorded.
- Overflow: output_enable high while full and no pop → event dropped (newest lost).
  - overflow set to 1.
  - overflow_count increments by 1 and saturates at 16'hFFFF; it never wraps.
  - FIFO contents are untouched.
- Clear:
  - Edge with clear = 1 → pointers, count, tvalid, overflow and overflow_count all go to 0.
  - clear has priority over push, pop and overflow in the same cycle; a simultaneous push is discarded and not counted.
  - A stream transfer in that same cycle completes from the downstream's view; the data is not re-sent.
- No state machine beyond the FIFO control: states are EMPTY, PARTIAL, FULL, derived from the count.
- Transitions: push-only +1, pop-only -1, push+pop 0, clear → EMPTY.
- fifo_full is registered alongside the count, never combinational from inputs.

Test Plan:
- Basic path: reset; one event core 3, value 16'hBEEF; tready = 1 → tvalid one cycle after the capture edge, tdata = 32'h0003BEEF, single-cycle transfer, fifo_count returns to 0.
- Back-to-back: 8 consecutive events with values 1..8 and tready held 1 → 8 words in order, tvalid continuous after the first, no gaps or duplicates, overflow stays 0.
- Fill and overflow: tready = 0, 20 events with DEPTH = 16 → fifo_full = 1 after 16, overflow = 1, overflow_count = 4.
  - Then raise tready → exactly the first 16 values drain in order.
- Full with concurrent push/pop: FIFO full, tready = 1 and output_enable = 1 in the same cycle → count stays 16, overflow_count unchanged, new value delivered last.
- Clear versus push: FIFO holding 5 entries with overflow_count = 3; clear and output_enable asserted together → count 0, tvalid 0, overflow_count 0, the pushed value never appears.
- Async reset: assert s_axi_aresetn low between clock edges while tvalid = 1 and tready = 0 → tvalid and count drop to 0 before the next edge.
  - After release, no stale word is emitted.
  - A new event is delivered normally.
